// File: rtl/axi_buffer_rab_bram_fwft.sv
// -----------------------------------------------------------------------------
// axi_buffer_rab_bram_fwft
//
// First-word-fall-through FIFO backed by a RAM with a one-cycle registered read.
// It buffers one RAB AXI channel between the AXI slave side and the translation
// pipeline. It provides programmable almost-full and almost-empty thresholds, a
// fill-level output, an optional push-while-full-with-pop mode and a sticky flag
// that records overflow attempts.
//
// Handshake: a beat transfers on a rising edge only when valid and ready are
// both high in that cycle. Upstream push = valid_in & ready_out. Downstream
// pop = valid_out & ready_in. valid_out and data_out depend only on registered
// state. ready_out depends combinationally on ready_in only when FULL_PASS=1.
//
// Ports
//   clk, rstn      clock (rising edge) and synchronous active-low reset
//   valid_in       upstream valid
//   data_in        upstream payload
//   ready_out      upstream ready
//   data_out       head-of-FIFO payload, meaningful while valid_out=1
//   valid_out      FIFO holds at least one entry
//   ready_in       downstream ready
//   flush_entries  drop all contents; beats pushed or popped this cycle are lost
//   level          current entry count
//   almost_full    level >= AF_THRESH
//   almost_empty   level <= AE_THRESH
//   overflow       sticky: valid_in seen while ready_out=0
//   clr_overflow   clears overflow; a new overflow in the same cycle wins
// -----------------------------------------------------------------------------
module axi_buffer_rab_bram_fwft #(
  parameter int DATA_WIDTH   = 64,
  parameter int BUFFER_DEPTH = 16,
  parameter int AF_THRESH    = BUFFER_DEPTH - 1,
  parameter int AE_THRESH    = 1,
  parameter int FULL_PASS    = 0
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  valid_in,
  input  logic [DATA_WIDTH-1:0]                 data_in,
  output logic                                  ready_out,
  output logic [DATA_WIDTH-1:0]                 data_out,
  output logic                                  valid_out,
  input  logic                                  ready_in,
  input  logic                                  flush_entries,
  output logic [$clog2(BUFFER_DEPTH+1)-1:0]     level,
  output logic                                  almost_full,
  output logic                                  almost_empty,
  output logic                                  overflow,
  input  logic                                  clr_overflow
);

  localparam int LVL_W = $clog2(BUFFER_DEPTH + 1);
  // The RAM has BUFFER_DEPTH+1 words, so addresses run from 0 to BUFFER_DEPTH.
  localparam int PTR_W = LVL_W;
  localparam logic [PTR_W-1:0] LAST_ADDR = PTR_W'(BUFFER_DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(BUFFER_DEPTH);
  localparam logic [LVL_W-1:0] AF_LVL    = LVL_W'(AF_THRESH);
  localparam logic [LVL_W-1:0] AE_LVL    = LVL_W'(AE_THRESH);

  // Storage and state
  logic [DATA_WIDTH-1:0] r_mem [0:BUFFER_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [LVL_W-1:0]      r_level;
  logic [DATA_WIDTH-1:0] r_ram_q;
  logic [DATA_WIDTH-1:0] r_bypass;
  logic                  r_use_bypass;
  logic                  r_overflow;

  // Combinational
  logic                  w_full;
  logic                  w_ready_out;
  logic                  w_valid_out;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_push_acc;
  logic                  w_pop_acc;
  logic [PTR_W-1:0]      w_wr_ptr_inc;
  logic [PTR_W-1:0]      w_rd_ptr_inc;
  logic [PTR_W-1:0]      w_addr_r;
  logic [DATA_WIDTH-1:0] w_head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_full      = (r_level == FULL_LVL);
  assign w_valid_out = (r_level != '0);

  generate
    if (FULL_PASS != 0) begin : g_full_pass
      // When full, a pop in the same cycle frees the slot the push needs.
      assign w_ready_out = !w_full || ready_in;
    end else begin : g_no_full_pass
      assign w_ready_out = !w_full;
    end
  endgenerate

  assign w_push     = valid_in && w_ready_out;
  assign w_pop      = w_valid_out && ready_in;
  // A flush cancels any transfer in the same cycle.
  assign w_push_acc = w_push && !flush_entries;
  assign w_pop_acc  = w_pop  && !flush_entries;

  assign w_wr_ptr_inc = ptr_inc(r_wr_ptr);
  assign w_rd_ptr_inc = ptr_inc(r_rd_ptr);

  // Read the word that will be the head next cycle, so the head is ready
  // right after a pop.
  assign w_addr_r = w_pop ? w_rd_ptr_inc : r_rd_ptr;

  // RAM write port. Contents are not reset.
  always_ff @(posedge clk) begin
    if (w_push_acc) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // RAM registered read port and bypass path.
  // When the address being read is also written in the same cycle, the RAM
  // returns stale data. This happens on the push into an empty FIFO, and on
  // push+pop at level 1. The pushed word is taken from the bypass register for
  // one cycle instead, so the RAM read-during-write mode never matters.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ram_q      <= '0;
      r_bypass     <= '0;
      r_use_bypass <= 1'b0;
    end else begin
      r_ram_q <= r_mem[w_addr_r];
      if (w_push_acc) begin
        r_bypass <= data_in;
      end
      r_use_bypass <= w_push_acc && (w_addr_r == r_wr_ptr);
    end
  end

  // Pointers and fill level
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush_entries) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_acc) r_wr_ptr <= w_wr_ptr_inc;
      if (w_pop_acc)  r_rd_ptr <= w_rd_ptr_inc;
      case ({w_push_acc, w_pop_acc})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky overflow flag. Flushing the FIFO does not clear it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_overflow <= 1'b0;
    end else if (valid_in && !w_ready_out) begin
      r_overflow <= 1'b1;
    end else if (clr_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  assign w_head = r_use_bypass ? r_bypass : r_ram_q;

  assign ready_out    = w_ready_out;
  assign valid_out    = w_valid_out;
  // Drive zero while empty so an unwritten RAM word never appears on data_out.
  assign data_out     = w_valid_out ? w_head : '0;
  assign level        = r_level;
  assign almost_full  = (r_level >= AF_LVL);
  assign almost_empty = (r_level <= AE_LVL);
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_axi_buffer_rab_bram_fwft.sv
// -----------------------------------------------------------------------------
// tb_axi_buffer_rab_bram_fwft
//
// Runs two instances side by side on the same inputs: u_dut0 with FULL_PASS=0
// and u_dut1 with FULL_PASS=1. Each instance has its own reference model, built
// from a queue of stored words and a sticky overflow bit. Every cycle, after
// the falling edge, the model's expected outputs are compared against the
// instance. The model then advances to represent the state after the next
// rising edge.
// -----------------------------------------------------------------------------
module tb_axi_buffer_rab_bram_fwft;

  localparam int DW = 64;
  localparam int D  = 16;
  localparam int AF = D - 1;
  localparam int AE = 1;
  localparam int LW = $clog2(D + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic          valid_in;
  logic [DW-1:0] data_in;
  logic          ready_in;
  logic          flush_entries;
  logic          clr_overflow;

  logic          ready_out0, valid_out0, almost_full0, almost_empty0, overflow0;
  logic [DW-1:0] data_out0;
  logic [LW-1:0] level0;
  logic          ready_out1, valid_out1, almost_full1, almost_empty1, overflow1;
  logic [DW-1:0] data_out1;
  logic [LW-1:0] level1;

  axi_buffer_rab_bram_fwft #(
    .DATA_WIDTH(DW), .BUFFER_DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FULL_PASS(0)
  ) u_dut0 (
    .clk(clk), .rstn(rstn), .valid_in(valid_in), .data_in(data_in),
    .ready_out(ready_out0), .data_out(data_out0), .valid_out(valid_out0),
    .ready_in(ready_in), .flush_entries(flush_entries), .level(level0),
    .almost_full(almost_full0), .almost_empty(almost_empty0),
    .overflow(overflow0), .clr_overflow(clr_overflow)
  );

  axi_buffer_rab_bram_fwft #(
    .DATA_WIDTH(DW), .BUFFER_DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FULL_PASS(1)
  ) u_dut1 (
    .clk(clk), .rstn(rstn), .valid_in(valid_in), .data_in(data_in),
    .ready_out(ready_out1), .data_out(data_out1), .valid_out(valid_out1),
    .ready_in(ready_in), .flush_entries(flush_entries), .level(level1),
    .almost_full(almost_full1), .almost_empty(almost_empty1),
    .overflow(overflow1), .clr_overflow(clr_overflow)
  );

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  logic          ovf_m0 = 1'b0, ovf_m1 = 1'b0;
  logic          just_rst0 = 1'b1, just_rst1 = 1'b1;
  logic          chk_en = 1'b0;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check_val(input string tag, input logic [DW-1:0] act,
                           input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Compare one instance against its model, then advance the model across
  // the coming rising edge.
  task automatic model_step(input int k);
    logic [DW-1:0] q[$];
    logic          ovf, jr, fp, rdy, vld, push, pop;
    int            lvl;
    logic [LW-1:0] a_lvl;
    logic          a_rdy, a_vld, a_af, a_ae, a_ovf;
    logic [DW-1:0] a_dat;
    if (k == 0) begin
      q = exp_q0; ovf = ovf_m0; jr = just_rst0; fp = 1'b0;
      a_lvl = level0; a_rdy = ready_out0; a_vld = valid_out0; a_dat = data_out0;
      a_af = almost_full0; a_ae = almost_empty0; a_ovf = overflow0;
    end else begin
      q = exp_q1; ovf = ovf_m1; jr = just_rst1; fp = 1'b1;
      a_lvl = level1; a_rdy = ready_out1; a_vld = valid_out1; a_dat = data_out1;
      a_af = almost_full1; a_ae = almost_empty1; a_ovf = overflow1;
    end

    lvl = q.size();
    rdy = (lvl != D) || (fp && ready_in);
    vld = (lvl != 0);

    check_val($sformatf("d%0d_level", k), DW'(a_lvl), DW'(lvl));
    check_val($sformatf("d%0d_valid_out", k), DW'(a_vld), DW'(vld));
    check_val($sformatf("d%0d_ready_out", k), DW'(a_rdy), DW'(rdy));
    check_val($sformatf("d%0d_almost_full", k), DW'(a_af), DW'(lvl >= AF));
    check_val($sformatf("d%0d_almost_empty", k), DW'(a_ae), DW'(lvl <= AE));
    check_val($sformatf("d%0d_overflow", k), DW'(a_ovf), DW'(ovf));
    if (vld) check_val($sformatf("d%0d_data_out", k), a_dat, q[0]);
    else if (jr) check_val($sformatf("d%0d_data_out_rst", k), a_dat, '0);
    jr = 1'b0;

    if (!rstn) begin
      q.delete();
      ovf = 1'b0;
      jr  = 1'b1;
    end else begin
      push = valid_in && rdy;
      pop  = vld && ready_in;
      if (flush_entries) begin
        q.delete();
      end else begin
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(data_in);
      end
      if (valid_in && !rdy) ovf = 1'b1;
      else if (clr_overflow) ovf = 1'b0;
    end

    if (k == 0) begin
      exp_q0 = q; ovf_m0 = ovf; just_rst0 = jr;
    end else begin
      exp_q1 = q; ovf_m1 = ovf; just_rst1 = jr;
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic vi, input logic [DW-1:0] di, input logic ri,
                       input logic fl, input logic co, input logic rn);
    @(negedge clk);
    rstn          = rn;
    valid_in      = vi;
    data_in       = di;
    ready_in      = ri;
    flush_entries = fl;
    clr_overflow  = co;
    #1;
    if (chk_en) begin
      model_step(0);
      model_step(1);
    end
  endtask

  task automatic push_beat(input logic [DW-1:0] di, input logic ri);
    cycle(1'b1, di, ri, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle(input logic ri, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, ri, 1'b0, 1'b0, 1'b1);
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom(), $urandom()};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rstn = 1'b0; valid_in = 1'b0; data_in = '0; ready_in = 1'b0;
    flush_entries = 1'b0; clr_overflow = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;

    // Single beat passes through with one-cycle latency.
    push_beat(64'hA5, 1'b1);
    idle(1'b1, 3);

    // Fill to full, attempt overflow, clear it, then drain in order.
    for (int i = 0; i < D; i++) push_beat(DW'(i), 1'b0);
    push_beat(64'h99, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1'b1, D + 2);

    // Continuous push with random downstream stalls, across pointer wraps.
    for (int i = 0; i < 100; i++) push_beat(rnd_word(), 1'($urandom_range(0, 1)));
    idle(1'b1, D + 2);

    // Push and pop in the same cycle while full.
    for (int i = 0; i < D; i++) push_beat(rnd_word(), 1'b0);
    push_beat(rnd_word(), 1'b1);
    push_beat(rnd_word(), 1'b1);
    push_beat(rnd_word(), 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(1'b1, D + 2);

    // Flush at level 7 while a push and a pop are requested in the same cycle.
    for (int i = 0; i < 7; i++) push_beat(rnd_word(), 1'b0);
    cycle(1'b1, 64'h77, 1'b1, 1'b1, 1'b0, 1'b1);
    push_beat(64'h3C, 1'b0);
    idle(1'b0, 2);
    idle(1'b1, 2);

    // Reset in the middle of a burst at level 9.
    for (int i = 0; i < 9; i++) push_beat(rnd_word(), 1'b0);
    cycle(1'b1, 64'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    push_beat(64'hA5, 1'b1);
    idle(1'b1, 3);

    // Random traffic including occasional flushes, overflow clears and resets.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), rnd_word(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 99) != 0));
    end
    idle(1'b1, D + 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
